// File: rtl/sub_seq_pkg.sv
// Shared types and constants for the nibble-serial subtract sequencer.
// The slice width and step count live here so the slice and the controller agree.
package sub_seq_pkg;

    localparam int SLICE  = 4;
    localparam int NSTEP  = 16 / SLICE;
    localparam int STEP_W = $clog2(NSTEP);

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_SBB = 2'b01,
        OP_CMP = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/sub_slice4.sv
// Combinational borrow-ripple subtractor slice: d = a - b - bin, bout = borrow out of the top bit.
module sub_slice4
    import sub_seq_pkg::*;
#(
    parameter int W = SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] brw;

    always_comb begin
        brw    = '0;
        d      = '0;
        brw[0] = bin;
        for (int i = 0; i < W; i++) begin
            d[i]     = a[i] ^ b[i] ^ brw[i];
            brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
        end
    end

    assign bout = brw[W];

endmodule

// File: rtl/sub_seq_ctrl.sv
// 16-bit subtract/compare sequencer that time-shares one narrow subtractor slice,
// LSB slice first, with valid/ready handshakes toward issue and writeback.
module sub_seq_ctrl
    import sub_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_bin,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_diff,
    output logic             rsp_borrow,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_ovf,
    output logic             busy
);

    localparam int NSTEPS    = WIDTH / SLICE;
    localparam int STEP_BITS = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(NSTEPS - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // req_ready is high only in IDLE, rsp_valid only in DONE, and DONE holds until rsp_ready.
    state_t               state;
    op_t                  op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     diff_q;
    logic [STEP_BITS-1:0] step;
    logic                 borrow_q;

    logic [SLICE-1:0]     slice_a;
    logic [SLICE-1:0]     slice_b;
    logic [SLICE-1:0]     slice_d;
    logic                 slice_bout;
    logic [WIDTH-1:0]     d_full;

    assign slice_a = a_q[step*SLICE +: SLICE];
    assign slice_b = b_q[step*SLICE +: SLICE];

    sub_slice4 #(.W(SLICE)) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bout)
    );

    // Full difference including the nibble being produced this cycle; used for the flags on the last step.
    always_comb begin
        d_full = diff_q;
        d_full[step*SLICE +: SLICE] = slice_d;
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_SUB;
            a_q        <= '0;
            b_q        <= '0;
            diff_q     <= '0;
            step       <= '0;
            borrow_q   <= 1'b0;
            rsp_diff   <= '0;
            rsp_borrow <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        a_q      <= req_a;
                        b_q      <= req_b;
                        op_q     <= op_t'(req_op);
                        diff_q   <= '0;
                        step     <= '0;
                        borrow_q <= (op_t'(req_op) == OP_SBB) ? req_bin : 1'b0;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    diff_q[step*SLICE +: SLICE] <= slice_d;
                    borrow_q <= slice_bout;
                    step     <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        // CMP still reports flags from the true difference, only the value is suppressed.
                        rsp_diff   <= (op_q == OP_CMP) ? '0 : d_full;
                        rsp_borrow <= slice_bout;
                        rsp_zero   <= (d_full == '0);
                        rsp_neg    <= d_full[WIDTH-1];
                        rsp_ovf    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (d_full[WIDTH-1] != a_q[WIDTH-1]);
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Directed bench for sub_seq_ctrl: a vector table of hand-computed results plus
// backpressure and mid-operation reset sequences.
module tb_sub_seq_ctrl;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [1:0]   op;
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         neg;
        logic         ovf;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_bin;
    logic [1:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_diff;
    logic         rsp_borrow;
    logic         rsp_zero;
    logic         rsp_neg;
    logic         rsp_ovf;
    logic         busy;

    int n_checks;
    int n_pass;

    vec_t vecs[12];

    sub_seq_ctrl #(.WIDTH(16), .SLICE(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_bin    (req_bin),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_diff   (rsp_diff),
        .rsp_borrow (rsp_borrow),
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Drive one request and wait for rsp_valid; lat is the number of edges after acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [1:0] op, output int lat);
        int waited;
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        check("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
        req_a = a; req_b = b; req_bin = bin; req_op = op; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("req_ready_in_calc", {31'b0, req_ready}, 32'd0);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid) break;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_ack", {31'b0, rsp_valid}, 32'd0);
        check("req_ready_after_ack", {31'b0, req_ready}, 32'd1);
        check("busy_after_ack", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_result(input vec_t v, input int lat);
        check("latency", lat, 32'd4);
        check("diff", {16'b0, rsp_diff}, {16'b0, v.diff});
        check("borrow", {31'b0, rsp_borrow}, {31'b0, v.borrow});
        check("zero", {31'b0, rsp_zero}, {31'b0, v.zero});
        check("neg", {31'b0, rsp_neg}, {31'b0, v.neg});
        check("ovf", {31'b0, rsp_ovf}, {31'b0, v.ovf});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_diff"}, {16'b0, rsp_diff}, 32'd0);
        check({tag, "_flags"}, {28'b0, rsp_borrow, rsp_zero, rsp_neg, rsp_ovf}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] held_diff;
        logic [3:0]   held_flags;

        n_checks = 0;
        n_pass   = 0;

        //          a         b         bin   op     diff      bo    z     n     o
        vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 2'b00, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 2'b00, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0000, 1'b1, 2'b01, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{16'h8000, 16'h0000, 1'b1, 2'b00, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h5555, 16'h5555, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'h0003, 16'h0005, 1'b0, 2'b10, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16'h0010, 16'h0001, 1'b1, 2'b11, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h0005, 16'h0005, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 16'hFFFF, 1'b1, 2'b01, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b0, 2'b01, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{16'h7FFF, 16'h8000, 1'b0, 2'b00, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{16'hABCD, 16'h1234, 1'b0, 2'b00, 16'h9999, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_bin = 1'b0;
        req_op = 2'b00; rsp_ready = 1'b0;
        #1;
        check_idle_outputs("in_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].op, lat);
            check_result(vecs[i], lat);
            release_rsp();
        end

        // Backpressure: hold DONE for three cycles while a stray request is offered.
        issue(16'h4321, 16'h1111, 1'b0, 2'b00, lat);
        check("bp_latency", lat, 32'd4);
        held_diff  = rsp_diff;
        held_flags = {rsp_borrow, rsp_zero, rsp_neg, rsp_ovf};
        check("bp_diff_value", {16'b0, held_diff}, 32'h3210);
        req_valid = 1'b1; req_a = 16'hFFFF; req_b = 16'h0001; req_op = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
            check("bp_diff_hold", {16'b0, rsp_diff}, {16'b0, held_diff});
            check("bp_flags_hold", {28'b0, rsp_borrow, rsp_zero, rsp_neg, rsp_ovf}, {28'b0, held_flags});
        end
        req_valid = 1'b0;
        release_rsp();
        issue(16'h0100, 16'h0001, 1'b0, 2'b00, lat);
        check_result('{16'h0100, 16'h0001, 1'b0, 2'b00, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0}, lat);
        release_rsp();

        // Reset in the second CALC cycle; previous result 0x00FF is still on rsp_diff.
        req_a = 16'h9876; req_b = 16'h0123; req_bin = 1'b0; req_op = 2'b00; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk); #1;
        check_idle_outputs("mid_reset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");
        issue(16'h0010, 16'h0001, 1'b0, 2'b00, lat);
        check_result('{16'h0010, 16'h0001, 1'b0, 2'b00, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0}, lat);
        release_rsp();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub_seq_ctrl.md
Name: sub_seq_ctrl

Overview:
- Multi-cycle sequencer that computes a 16-bit subtraction by time-sharing one 4-bit borrow-ripple subtractor slice over four clocks, LSB nibble first.
- Carries the borrow between nibbles in a register and derives ALU status flags.
- Sits between the CPU execute-stage issue logic and the register-file writeback, with a valid/ready handshake on each side.
- Trades three extra cycles for one quarter of the subtractor area.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, width of the shared subtractor slice; NSTEP = WIDTH/SLICE = 4 steps.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  WIDTH  minuend.
- req_b  in  WIDTH  subtrahend.
- req_bin  in  1  borrow-in; used only by SBB.
- req_op  in  2  00 SUB, 01 SBB, 10 CMP, 11 reserved (executes as SUB).
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_diff  out  WIDTH  difference; forced to 0 for CMP.
- rsp_borrow  out  1  borrow out of the MSB (unsigned a < b + bin).
- rsp_zero  out  1  true difference == 0, for all ops including CMP.
- rsp_neg  out  1  true difference bit WIDTH-1.
- rsp_ovf  out  1  signed overflow.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: asynchronous on rst_n low; takes effect immediately, including mid-operation.
  - State goes to IDLE; operand, step and borrow registers clear; any in-flight request is discarded, with no response.
  - Outputs during and after reset: req_ready=1, rsp_valid=0, rsp_diff=0, all flags 0, busy=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch a, b and op; step=0; borrow register = (op==SBB) ? req_bin : 0. Go to CALC.
- CALC:
  - req_ready=0.
  - Each cycle the slice computes a[step], b[step] and the borrow register; the result nibble is written into the diff register at index step, and the borrow register takes the slice borrow-out.
  - step increments each cycle. On the edge where step==NSTEP-1, go to DONE.
- DONE:
  - rsp_valid=1; all rsp_* outputs are registered and stable.
  - Hold until rsp_ready; then go to IDLE on that edge.
  - rsp_valid is not asserted in the IDLE cycle that follows.
- Latency: request accepted at edge E0; rsp_valid high from edge E0+NSTEP (4 clocks).
  - Minimum issue interval NSTEP+2 = 6 clocks (one IDLE bubble).
- Backpressure: while rsp_ready=0 in DONE, every output is held constant and req_ready stays 0. req_valid is ignored outside IDLE.
- Flags, all computed on the full true difference d, regardless of op:
  - zero = (d==0).
  - neg = d[WIDTH-1].
  - borrow = final borrow register.
  - ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]).
- Arithmetic is modulo 2^WIDTH; wrap-around is reported only through borrow and ovf.
- Reserved op 11 behaves exactly as SUB (bin ignored, diff reported).

Decomposition:
- Package sub_seq_pkg:
  - op enum: OP_SUB, OP_SBB, OP_CMP, OP_RSV.
  - state enum: ST_IDLE, ST_CALC, ST_DONE.
  - constants SLICE and NSTEP; step counter width $clog2(NSTEP).
- One sub-module sub_slice4: purely combinational SLICE-bit borrow-ripple subtractor.
  - Ports: a, b, bin, d, bout.
  - Instantiated once in sub_seq_ctrl.

Test Plan:
- SUB a=0x1234, b=0x0234, accepted at E0 -> rsp_valid high at E0+4; diff=0x1000, borrow=0, zero=0, neg=0, ovf=0.
- SUB a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, neg=1, zero=0, ovf=0.
- SBB a=0x8000, b=0x0000, bin=1 -> diff=0x7FFF, borrow=0, neg=0, ovf=1. Same operands with op=SUB -> diff=0x8000, ovf=0.
- CMP a=0x5555, b=0x5555 -> diff=0x0000, zero=1, borrow=0. CMP a=0x0003, b=0x0005 -> diff=0x0000, borrow=1, neg=1, zero=0.
- Hold rsp_ready=0 for 3 cycles in DONE -> all rsp_* stable, req_ready=0, a new req_valid is ignored. Then raise rsp_ready -> IDLE next cycle, req_ready=1, next request accepted normally.
- Pull rst_n low in the 2nd CALC cycle -> immediately busy=0, rsp_valid=0, req_ready=1, outputs 0. After release, SUB 0x0010-0x0001 -> diff=0x000F, with no residue from the aborted operation.
